// File: rtl/asg_seg_sequencer.sv
// Segment sequencer for one ASG channel: plays an 8-entry table of pointer
// configurations (size/step/ofs) with per-segment dwell, optionally looping.
module asg_seg_sequencer #(
  parameter int RSZ = 14
) (
  input  logic             dac_clk_i,
  input  logic             dac_rst_i,
  input  logic             tbl_we_i,
  input  logic [2:0]       tbl_addr_i,
  input  logic [1:0]       tbl_sel_i,
  input  logic [31:0]      tbl_wdata_i,
  output logic [31:0]      tbl_rdata_o,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [2:0]       seg_last_i,
  input  logic [15:0]      nloop_i,
  output logic [RSZ+15:0]  set_size_o,
  output logic [RSZ+15:0]  set_step_o,
  output logic [RSZ+15:0]  set_ofs_o,
  output logic             set_rst_o,
  output logic             trig_sw_o,
  output logic [2:0]       seg_o,
  output logic [15:0]      pass_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int PW = RSZ + 16;

  typedef enum logic [1:0] {IDLE, LOAD, TRIG, RUN} state_t;

  state_t        state_reg;
  logic [PW-1:0] size_tbl  [8];
  logic [PW-1:0] step_tbl  [8];
  logic [PW-1:0] ofs_tbl   [8];
  logic [31:0]   dwell_tbl [8];
  logic [31:0]   dwell_lat_reg;
  logic [31:0]   dwell_cnt_reg;

  logic [2:0]    seg_inc;
  logic [16:0]   pass_inc;
  logic [15:0]   pass_sat;
  logic          more_passes;
  logic          seg_adv;
  logic          load_go;
  logic [2:0]    ld_idx;

  // Table storage is cleared by reset, so it lives in flops rather than RAM.
  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      for (int i = 0; i < 8; i++) begin
        size_tbl[i]  <= '0;
        step_tbl[i]  <= '0;
        ofs_tbl[i]   <= '0;
        dwell_tbl[i] <= '0;
      end
    end else if (tbl_we_i) begin
      case (tbl_sel_i)
        2'd0:    size_tbl[tbl_addr_i]  <= tbl_wdata_i[PW-1:0];
        2'd1:    step_tbl[tbl_addr_i]  <= tbl_wdata_i[PW-1:0];
        2'd2:    ofs_tbl[tbl_addr_i]   <= tbl_wdata_i[PW-1:0];
        default: dwell_tbl[tbl_addr_i] <= tbl_wdata_i;
      endcase
    end
  end

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      tbl_rdata_o <= '0;
    end else begin
      case (tbl_sel_i)
        2'd0:    tbl_rdata_o <= 32'(size_tbl[tbl_addr_i]);
        2'd1:    tbl_rdata_o <= 32'(step_tbl[tbl_addr_i]);
        2'd2:    tbl_rdata_o <= 32'(ofs_tbl[tbl_addr_i]);
        default: tbl_rdata_o <= dwell_tbl[tbl_addr_i];
      endcase
    end
  end

  // Advance decision for the last RUN cycle; limits are sampled live.
  always_comb begin
    seg_inc     = seg_o + 3'd1;
    pass_inc    = {1'b0, pass_o} + 17'd1;
    pass_sat    = pass_inc[16] ? 16'hFFFF : pass_inc[15:0];
    more_passes = (nloop_i == 16'd0) || (pass_inc < {1'b0, nloop_i});
    seg_adv     = (seg_o < seg_last_i);
    load_go     = !stop_i &&
                  (((state_reg == IDLE) && start_i) ||
                   ((state_reg == RUN) && (dwell_cnt_reg == 32'd1) &&
                    (seg_adv || more_passes)));
    ld_idx      = ((state_reg == RUN) && seg_adv) ? seg_inc : 3'd0;
  end

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      state_reg     <= IDLE;
      set_rst_o     <= 1'b1;
      trig_sw_o     <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      seg_o         <= '0;
      pass_o        <= '0;
      set_size_o    <= '0;
      set_step_o    <= '0;
      set_ofs_o     <= '0;
      dwell_lat_reg <= '0;
      dwell_cnt_reg <= '0;
    end else begin
      trig_sw_o <= 1'b0;
      done_o    <= 1'b0;
      // Snapshot the entry on LOAD entry so later writes never disturb a running segment.
      if (load_go) begin
        set_size_o    <= size_tbl[ld_idx];
        set_step_o    <= step_tbl[ld_idx];
        set_ofs_o     <= ofs_tbl[ld_idx];
        dwell_lat_reg <= dwell_tbl[ld_idx];
        set_rst_o     <= 1'b1;
        state_reg     <= LOAD;
      end
      if (stop_i) begin
        state_reg <= IDLE;
        busy_o    <= 1'b0;
        set_rst_o <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            set_rst_o <= 1'b1;
            if (start_i) begin
              busy_o <= 1'b1;
              seg_o  <= 3'd0;
              pass_o <= 16'd0;
            end
          end
          LOAD: begin
            set_rst_o <= 1'b0;
            trig_sw_o <= 1'b1;
            state_reg <= TRIG;
          end
          TRIG: begin
            dwell_cnt_reg <= (dwell_lat_reg == 32'd0) ? 32'd1 : dwell_lat_reg;
            state_reg     <= RUN;
          end
          RUN: begin
            dwell_cnt_reg <= dwell_cnt_reg - 32'd1;
            if (dwell_cnt_reg == 32'd1) begin
              if (seg_adv) begin
                seg_o <= seg_inc;
              end else begin
                pass_o <= pass_sat;
                if (more_passes) begin
                  seg_o <= 3'd0;
                end else begin
                  state_reg <= IDLE;
                  busy_o    <= 1'b0;
                  set_rst_o <= 1'b1;
                  done_o    <= 1'b1;
                end
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_asg_seg_sequencer.sv
// Scoreboard bench for asg_seg_sequencer: a timeline model predicts every
// trigger/done event; a negedge monitor pops and compares as events appear.
`timescale 1ns/1ps
module tb_asg_seg_sequencer;
  localparam int RSZ = 14;
  localparam int PW  = RSZ + 16;
  localparam int NO_STOP = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tbl_we = 1'b0;
  logic [2:0] tbl_addr = '0;
  logic [1:0] tbl_sel = '0;
  logic [31:0] tbl_wdata = '0;
  logic [31:0] tbl_rdata;
  logic start_i = 1'b0, stop_i = 1'b0;
  logic [2:0] seg_last = '0;
  logic [15:0] nloop = '0;
  logic [PW-1:0] set_size, set_step, set_ofs;
  logic set_rst, trig_sw, busy, done;
  logic [2:0] seg_o;
  logic [15:0] pass_o;

  asg_seg_sequencer #(.RSZ(RSZ)) dut (
    .dac_clk_i(clk), .dac_rst_i(rst),
    .tbl_we_i(tbl_we), .tbl_addr_i(tbl_addr), .tbl_sel_i(tbl_sel),
    .tbl_wdata_i(tbl_wdata), .tbl_rdata_o(tbl_rdata),
    .start_i(start_i), .stop_i(stop_i), .seg_last_i(seg_last), .nloop_i(nloop),
    .set_size_o(set_size), .set_step_o(set_step), .set_ofs_o(set_ofs),
    .set_rst_o(set_rst), .trig_sw_o(trig_sw), .seg_o(seg_o), .pass_o(pass_o),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int cyc;
    int seg;
    int pass;
    logic [PW-1:0] size, step, ofs;
  } ev_t;

  ev_t exp_q[$];
  int  obs_trig[$];
  int  checks = 0, passed = 0;
  logic [PW-1:0] m_size[8], m_step[8], m_ofs[8];
  logic [31:0]   m_dwell[8];
  bit pw_valid = 0;
  int pw_rel, pw_cyc, pw_addr, pw_sel;
  logic [31:0] pw_data;
  int exp_seg, exp_pass;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void m_write(int a, int s, logic [31:0] d);
    case (s)
      0: m_size[a] = d[PW-1:0];
      1: m_step[a] = d[PW-1:0];
      2: m_ofs[a]  = d[PW-1:0];
      default: m_dwell[a] = d;
    endcase
  endfunction

  // Walks the playback timeline: each segment starts with a load at edge t,
  // triggers at t+1 and lasts 2+max(dwell,1) edges; events at or after a stop/reset edge never happen.
  task automatic model_run(int e0, int last, int nl, int stop_e);
    int t, sg, ps, d, tn;
    ev_t ev;
    t = e0 + 1; sg = 0; ps = 0;
    forever begin
      if (pw_valid && pw_cyc < t) begin
        m_write(pw_addr, pw_sel, pw_data);
        pw_valid = 0;
      end
      if (t + 1 >= stop_e) break;
      ev.is_done = 0; ev.cyc = t + 1; ev.seg = sg; ev.pass = ps;
      ev.size = m_size[sg]; ev.step = m_step[sg]; ev.ofs = m_ofs[sg];
      exp_q.push_back(ev);
      d  = (m_dwell[sg] == 0) ? 1 : int'(m_dwell[sg]);
      tn = t + 2 + d;
      if (tn >= stop_e) break;
      if (sg < last) begin
        sg++;
      end else begin
        ps = (ps == 65535) ? ps : ps + 1;
        if (nl == 0 || ps < nl) begin
          sg = 0;
        end else begin
          ev.is_done = 1; ev.cyc = tn; ev.seg = sg; ev.pass = ps;
          ev.size = '0; ev.step = '0; ev.ofs = '0;
          exp_q.push_back(ev);
          break;
        end
      end
      t = tn;
    end
    if (pw_valid) begin
      m_write(pw_addr, pw_sel, pw_data);
      pw_valid = 0;
    end
    exp_seg = sg; exp_pass = ps;
  endtask

  always @(negedge clk) begin : monitor
    ev_t ev;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (trig_sw || done) begin
        $display("cyc=%0d %s seg=%0d pass=%0d size=%0h step=%0h ofs=%0h",
                 cyc, done ? "done" : "trig", seg_o, pass_o, set_size, set_step, set_ofs);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          ev = exp_q.pop_front();
          chk("event_kind", done, ev.is_done);
          chk("event_cycle", cyc, ev.cyc);
          chk("event_seg", seg_o, ev.seg);
          chk("event_pass", pass_o, ev.pass);
          if (trig_sw) begin
            obs_trig.push_back(cyc);
            chk("trig_cfg", {set_size, set_step, set_ofs}, {ev.size, ev.step, ev.ofs});
            chk("trig_busy_rst", {busy, set_rst}, 2'b10);
          end else begin
            chk("done_busy_rst", {busy, set_rst}, 2'b01);
          end
        end
      end
    end
  end

  task automatic tbl_write(int a, int s, logic [31:0] d);
    @(negedge clk);
    tbl_we = 1; tbl_addr = 3'(a); tbl_sel = 2'(s); tbl_wdata = d;
    @(negedge clk);
    tbl_we = 0;
    m_write(a, s, d);
  endtask

  task automatic rd_check(int a, int s);
    logic [31:0] e;
    @(negedge clk);
    tbl_addr = 3'(a); tbl_sel = 2'(s);
    @(negedge clk);
    case (s)
      0: e = 32'(m_size[a]);
      1: e = 32'(m_step[a]);
      2: e = 32'(m_ofs[a]);
      default: e = m_dwell[a];
    endcase
    chk("table_readback", tbl_rdata, e);
  endtask

  task automatic launch(int last, int nl, int stop_rel, output int e0);
    @(negedge clk);
    e0 = cyc;
    if (pw_valid) pw_cyc = e0 + pw_rel;
    model_run(e0, last, nl, (stop_rel == 0) ? NO_STOP : e0 + stop_rel);
    seg_last = 3'(last); nloop = 16'(nl); start_i = 1;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_stop(int s_edge);
    wait_until(s_edge - 1);
    stop_i = 1;
    @(negedge clk);
    stop_i = 0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk("run_terminates", busy, 0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("final_seg", seg_o, exp_seg);
    chk("final_pass", pass_o, exp_pass);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, last, nl, srel;
    int exp_tr[6] = '{2, 9, 21, 24, 31, 43};
    logic [PW-1:0] old_size;
    for (int i = 0; i < 8; i++) begin
      m_size[i] = '0; m_step[i] = '0; m_ofs[i] = '0; m_dwell[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_ctrl", {set_rst, trig_sw, busy, done}, 4'b1000);
    chk("reset_seg_pass", {seg_o, pass_o}, 0);
    chk("reset_cfg", {set_size, set_step, set_ofs}, 0);
    chk("reset_rdata", tbl_rdata, 0);

    // Single long segment.
    tbl_write(0, 0, 32'h3FFF0000); tbl_write(0, 1, 32'h10000);
    tbl_write(0, 2, 32'h0);        tbl_write(0, 3, 32'd100);
    rd_check(0, 0);
    launch(0, 1, 0, e0);
    wait_idle(300);

    // Three segments, two passes; a stray start mid-run must be ignored.
    tbl_write(1, 0, 32'h00100000); tbl_write(1, 3, 32'd10);
    tbl_write(2, 0, 32'h00200000); tbl_write(2, 2, 32'h00050000); tbl_write(2, 3, 32'd0);
    tbl_write(0, 3, 32'd5);
    obs_trig.delete();
    launch(2, 2, 0, e0);
    wait_until(e0 + 14);
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    wait_idle(300);
    chk("t2_trig_count", obs_trig.size(), 6);
    for (int i = 0; i < 6 && i < obs_trig.size(); i++)
      chk("t2_trig_cycle", obs_trig[i] - e0, exp_tr[i]);

    // Infinite looping, then abort.
    tbl_write(0, 3, 32'd1); tbl_write(1, 3, 32'd2); tbl_write(2, 3, 32'd0);
    launch(2, 0, 125, e0);
    pulse_stop(e0 + 125);
    chk("stop_idle_ctrl", {busy, set_rst, done}, 3'b010);
    chk("stop_many_passes", pass_o > 16'd10, 1);
    wait_idle(20);

    // Table write to entry 1 during its RUN shows up only on the next pass.
    tbl_write(0, 3, 32'd8); tbl_write(1, 3, 32'd8);
    old_size = m_size[1];
    pw_valid = 1; pw_rel = 15; pw_addr = 1; pw_sel = 0; pw_data = 32'h01230000;
    launch(1, 2, 0, e0);
    wait_until(e0 + 14);
    tbl_we = 1; tbl_addr = 3'd1; tbl_sel = 2'd0; tbl_wdata = 32'h01230000;
    @(negedge clk);
    tbl_we = 0;
    @(negedge clk);
    chk("running_seg_unaffected", set_size, old_size);
    wait_idle(100);

    // Async reset mid-run.
    tbl_write(0, 3, 32'd10); tbl_write(1, 3, 32'd10); tbl_write(2, 3, 32'd10);
    tbl_write(3, 3, 32'd7);
    launch(2, 1, 21, e0);
    wait_until(e0 + 20);
    rst = 1;
    #1;
    chk("async_rst_ctrl", {set_rst, trig_sw, busy, done}, 4'b1000);
    chk("async_rst_state", {seg_o, pass_o, tbl_rdata}, 0);
    chk("async_rst_cfg", {set_size, set_step, set_ofs}, 0);
    chk("pre_reset_events", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      m_size[i] = '0; m_step[i] = '0; m_ofs[i] = '0; m_dwell[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 0;
    rd_check(3, 3);
    tbl_write(0, 0, 32'h00ABC000); tbl_write(0, 3, 32'd4);
    launch(0, 2, 0, e0);
    wait_idle(100);

    // Start together with stop in IDLE: nothing happens.
    @(negedge clk);
    start_i = 1; stop_i = 1;
    @(negedge clk);
    start_i = 0; stop_i = 0;
    repeat (4) @(negedge clk);
    chk("start_stop_idle", {busy, set_rst}, 2'b01);

    // Randomised runs, some aborted.
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 8; a++) begin
        tbl_write(a, 0, $urandom); tbl_write(a, 1, $urandom);
        tbl_write(a, 2, $urandom); tbl_write(a, 3, $urandom_range(0, 6));
      end
      rd_check($urandom_range(0, 7), $urandom_range(0, 3));
      last = $urandom_range(0, 7);
      nl   = $urandom_range(1, 3);
      srel = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 80) : 0;
      launch(last, nl, srel, e0);
      if (srel != 0) pulse_stop(e0 + srel);
      wait_idle(1000);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
